// File: rtl/wolfram_scan_pkg.sv
// Shared types for the Wolfram truth-table scanner: FSM states, row type, bit indexing.
package wolfram_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic [2:0] row_t;

    localparam row_t LAST_ROW = 3'd7;

    // Row {in1,in2,in3}=r lands in bit (7-r) of a Wolfram code.
    function automatic logic [2:0] wbit(input row_t row);
        return 3'd7 - row;
    endfunction

endpackage

// File: rtl/wolfram_truth_scanner_if.sv
// Control, gate stimulus and result bus of the truth scanner.
interface wolfram_truth_scanner_if;

    logic       start;
    logic       abort;
    logic       dut_out;
    logic       drv_in1;
    logic       drv_in2;
    logic       drv_in3;
    logic       busy;
    logic       done;
    logic [7:0] measured;
    logic [7:0] mismatch;
    logic [7:0] glitch;
    logic       pass;

    modport master (
        output start, abort, dut_out,
        input  drv_in1, drv_in2, drv_in3, busy, done, measured, mismatch, glitch, pass
    );

    modport slave (
        input  start, abort, dut_out,
        output drv_in1, drv_in2, drv_in3, busy, done, measured, mismatch, glitch, pass
    );

endinterface

// File: rtl/wolfram_truth_scanner_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Latency: load takes effect on the next edge; a load of N-1 gives an N-cycle window.
// No backpressure: en simply holds the count when low.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/wolfram_truth_scanner.sv
// Walks a 3-input gate through all 8 rows and rebuilds its Wolfram code from the sampled output.
// Latency: done pulses 1+8*(SETTLE_CYCLES+SAMPLE_CYCLES) cycles after start is sampled.
// No backpressure: start is ignored while busy; abort returns to idle on the next cycle.
module wolfram_truth_scanner
    import wolfram_scan_pkg::*;
#(
    parameter logic [7:0] EXPECTED      = 8'h6F,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         SAMPLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    wolfram_truth_scanner_if.slave  bus
);

    localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    row_t          row;
    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_tc;
    logic [CW-1:0] tmr_val;
    logic          scan_clr;
    logic          enter_smp;
    logic          capture;
    logic          row_adv;
    logic          finish;
    logic          kill;
    logic          first_pend;
    logic          ref_bit;
    logic [7:0]    measured_q;
    logic [7:0]    glitch_q;
    logic [7:0]    mismatch_q;
    logic [7:0]    meas_nxt;
    logic [7:0]    glit_nxt;
    logic          pass_q;

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = SETTLE_LD;
        tmr_en    = 1'b0;
        scan_clr  = 1'b0;
        enter_smp = 1'b0;
        capture   = 1'b0;
        row_adv   = 1'b0;
        finish    = 1'b0;
        kill      = 1'b0;
        if (bus.abort && (state != IDLE)) begin
            kill      = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        scan_clr  = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = SETTLE_LD;
                        state_nxt = SETTLE;
                    end
                end
                SETTLE: begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        tmr_load  = 1'b1;
                        tmr_val   = SAMPLE_LD;
                        enter_smp = 1'b1;
                        state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    tmr_en  = 1'b1;
                    capture = 1'b1;
                    if (tmr_tc) begin
                        if (row == LAST_ROW) begin
                            finish    = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            row_adv   = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_val   = SETTLE_LD;
                            state_nxt = SETTLE;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The first sample of a row is the reference; any later disagreement marks a glitch.
    always_comb begin
        meas_nxt = measured_q;
        glit_nxt = glitch_q;
        if (capture) begin
            meas_nxt[wbit(row)] = bus.dut_out;
            if (!first_pend && (bus.dut_out != ref_bit)) begin
                glit_nxt[wbit(row)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row        <= '0;
            measured_q <= '0;
            glitch_q   <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            first_pend <= 1'b0;
            ref_bit    <= 1'b0;
        end else if (scan_clr) begin
            row        <= '0;
            measured_q <= '0;
            glitch_q   <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
        end else if (kill) begin
            row    <= '0;
            pass_q <= 1'b0;
        end else begin
            measured_q <= meas_nxt;
            glitch_q   <= glit_nxt;
            if (enter_smp) begin
                first_pend <= 1'b1;
            end
            if (capture) begin
                first_pend <= 1'b0;
                if (first_pend) begin
                    ref_bit <= bus.dut_out;
                end
            end
            if (row_adv) begin
                row <= row + 3'd1;
            end
            if (finish) begin
                row        <= '0;
                mismatch_q <= meas_nxt ^ EXPECTED;
                pass_q     <= (meas_nxt == EXPECTED) && (glit_nxt == 8'h00);
            end
        end
    end

    // The row register doubles as the gate stimulus, so drv only moves at row boundaries.
    assign bus.drv_in1  = row[2];
    assign bus.drv_in2  = row[1];
    assign bus.drv_in3  = row[0];
    assign bus.busy     = (state == SETTLE) || (state == SAMPLE);
    assign bus.done     = (state == DONE);
    assign bus.measured = measured_q;
    assign bus.mismatch = mismatch_q;
    assign bus.glitch   = glitch_q;
    assign bus.pass     = pass_q;

endmodule

// File: tb/tb_wolfram_truth_scanner.sv
// Bench for wolfram_truth_scanner: a modelled gate with per-sample disturbances, checked per scenario.
module tb_wolfram_truth_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wolfram_truth_scanner_if bus();

    wolfram_truth_scanner #(
        .EXPECTED      (8'h6F),
        .SETTLE_CYCLES (16),
        .SAMPLE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] gate_code;
    logic       flip;
    logic [3:0] flip_pat [8];
    bit         noise_en;
    int         extra_start [$];
    logic [2:0] drv;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_meas, got_mis, got_gl;
    logic       got_pass;
    int         done_cyc, done_cnt;
    bit         seq_ok;

    assign drv         = {bus.drv_in1, bus.drv_in2, bus.drv_in3};
    assign bus.dut_out = gate_code[~drv] ^ flip;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample r*4+i sees gate bit (7-r) xor flip_pat[r][i]; last sample wins, any change from the first is a glitch.
    task automatic model(input logic [7:0] code, output logic [7:0] m, output logic [7:0] g);
        logic s0, s;
        m = 8'h00;
        g = 8'h00;
        for (int r = 0; r < 8; r++) begin
            s0 = code[7-r] ^ flip_pat[r][0];
            for (int i = 0; i < 4; i++) begin
                s = code[7-r] ^ flip_pat[r][i];
                if (s != s0) g[7-r] = 1'b1;
                m[7-r] = s;
            end
        end
    endtask

    task automatic clear_flips();
        for (int r = 0; r < 8; r++) flip_pat[r] = 4'b0000;
    endtask

    // One full scan; cycle 1 is the first cycle after the edge that samples start.
    task automatic drive_scan();
        done_cyc  = -1;
        done_cnt  = 0;
        seq_ok    = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            int r, k;
            logic [2:0] exp_drv;
            r = (c - 1) / 20;
            k = (c - 1) % 20;
            if (r < 8 && k >= 16) flip = flip_pat[r][k-16];
            else if (r < 8 && noise_en) flip = 1'($urandom);
            else flip = 1'b0;
            bus.start = 1'b0;
            foreach (extra_start[j]) if (extra_start[j] == c) bus.start = 1'b1;
            exp_drv = (r < 8) ? 3'(r) : 3'd0;
            if (drv !== exp_drv) seq_ok = 1'b0;
            if (bus.busy !== ((c <= 160) ? 1'b1 : 1'b0)) seq_ok = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got_meas = bus.measured;
                    got_mis  = bus.mismatch;
                    got_gl   = bus.glitch;
                    got_pass = bus.pass;
                end
            end
            step();
        end
        flip      = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; flip = 1'b0; gate_code = 8'h6F;
        noise_en = 1'b0;
        clear_flips();
        repeat (3) @(posedge clk);
        #1;
        total++; if (drv !== 3'b000) begin bad++; $display("FAIL reset_drv: got %b want 000", drv); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.measured !== 8'h00) begin bad++; $display("FAIL reset_measured: got %h want 00", bus.measured); end
        total++; if (bus.mismatch !== 8'h00) begin bad++; $display("FAIL reset_mismatch: got %h want 00", bus.mismatch); end
        total++; if (bus.glitch !== 8'h00) begin bad++; $display("FAIL reset_glitch: got %h want 00", bus.glitch); end
        total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_gate_6f();
        gate_code = 8'h6F; noise_en = 1'b1; clear_flips(); extra_start = {};
        drive_scan();
        total++; if (done_cyc != 161) begin bad++; $display("FAIL gate6f_latency: got %0d want 161", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL gate6f_done_count: got %0d want 1", done_cnt); end
        total++; if (!seq_ok) begin bad++; $display("FAIL gate6f_drv_busy_walk: got bad sequence want 000..111 then 000"); end
        total++; if (got_meas !== 8'h6F) begin bad++; $display("FAIL gate6f_measured: got %h want 6f", got_meas); end
        total++; if (got_mis !== 8'h00) begin bad++; $display("FAIL gate6f_mismatch: got %h want 00", got_mis); end
        total++; if (got_gl !== 8'h00) begin bad++; $display("FAIL gate6f_glitch: got %h want 00", got_gl); end
        total++; if (got_pass !== 1'b1) begin bad++; $display("FAIL gate6f_pass: got %b want 1", got_pass); end
        total++; if (bus.pass !== 1'b1) begin bad++; $display("FAIL gate6f_pass_held: got %b want 1", bus.pass); end
    endtask

    task automatic test_tied_zero();
        gate_code = 8'h00; noise_en = 1'b1; clear_flips(); extra_start = {};
        drive_scan();
        total++; if (done_cyc != 161) begin bad++; $display("FAIL tied0_latency: got %0d want 161", done_cyc); end
        total++; if (got_meas !== 8'h00) begin bad++; $display("FAIL tied0_measured: got %h want 00", got_meas); end
        total++; if (got_mis !== 8'h6F) begin bad++; $display("FAIL tied0_mismatch: got %h want 6f", got_mis); end
        total++; if (got_gl !== 8'h00) begin bad++; $display("FAIL tied0_glitch: got %h want 00", got_gl); end
        total++; if (got_pass !== 1'b0) begin bad++; $display("FAIL tied0_pass: got %b want 0", got_pass); end
    endtask

    task automatic test_glitch_row3();
        gate_code = 8'h6F; noise_en = 1'b0; clear_flips(); extra_start = {};
        flip_pat[3] = 4'b0010;
        drive_scan();
        total++; if (got_gl !== 8'h10) begin bad++; $display("FAIL glitch3_glitch: got %h want 10", got_gl); end
        total++; if (got_meas !== 8'h6F) begin bad++; $display("FAIL glitch3_measured: got %h want 6f", got_meas); end
        total++; if (got_mis !== 8'h00) begin bad++; $display("FAIL glitch3_mismatch: got %h want 00", got_mis); end
        total++; if (got_pass !== 1'b0) begin bad++; $display("FAIL glitch3_pass: got %b want 0", got_pass); end
        clear_flips();
    endtask

    task automatic test_random();
        logic [7:0] em, eg;
        for (int it = 0; it < 6; it++) begin
            gate_code = (it % 3 == 0) ? 8'h6F : 8'($urandom);
            noise_en  = 1'b1;
            extra_start = {};
            for (int r = 0; r < 8; r++)
                flip_pat[r] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            model(gate_code, em, eg);
            drive_scan();
            total++; if (done_cyc != 161) begin bad++; $display("FAIL rand%0d_latency: got %0d want 161", it, done_cyc); end
            total++; if (got_meas !== em) begin bad++; $display("FAIL rand%0d_measured: got %h want %h", it, got_meas, em); end
            total++; if (got_mis !== (em ^ 8'h6F)) begin bad++; $display("FAIL rand%0d_mismatch: got %h want %h", it, got_mis, em ^ 8'h6F); end
            total++; if (got_gl !== eg) begin bad++; $display("FAIL rand%0d_glitch: got %h want %h", it, got_gl, eg); end
            total++; if (got_pass !== ((em == 8'h6F) && (eg == 8'h00))) begin bad++; $display("FAIL rand%0d_pass: got %b want %b", it, got_pass, (em == 8'h6F) && (eg == 8'h00)); end
        end
        clear_flips();
    endtask

    task automatic test_abort();
        int dones;
        gate_code = 8'h6F; noise_en = 1'b0; clear_flips(); extra_start = {};
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_start_together_busy: got %b want 0", bus.busy); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 106; c++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        total++; if (drv !== 3'b000) begin bad++; $display("FAIL abort_drv: got %b want 000", drv); end
        total++; if (bus.measured !== 8'h68) begin bad++; $display("FAIL abort_partial_measured: got %h want 68", bus.measured); end
        total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL abort_pass: got %b want 0", bus.pass); end
        dones = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        drive_scan();
        total++; if (done_cyc != 161) begin bad++; $display("FAIL abort_restart_latency: got %0d want 161", done_cyc); end
        total++; if (got_pass !== 1'b1) begin bad++; $display("FAIL abort_restart_pass: got %b want 1", got_pass); end
    endtask

    task automatic test_reset_mid();
        gate_code = 8'h6F; noise_en = 1'b0; clear_flips(); extra_start = {};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 58; c++) step();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || drv !== 3'b000 || bus.done !== 1'b0) begin bad++;
            $display("FAIL rstmid_ctrl: got busy=%b drv=%b done=%b want 0 000 0", bus.busy, drv, bus.done); end
        total++; if (bus.measured !== 8'h00 || bus.glitch !== 8'h00 || bus.mismatch !== 8'h00 || bus.pass !== 1'b0) begin bad++;
            $display("FAIL rstmid_results: got m=%h g=%h x=%h p=%b want 00 00 00 0", bus.measured, bus.glitch, bus.mismatch, bus.pass); end
        step();
        rst = 1'b0;
        step();
        drive_scan();
        total++; if (done_cyc != 161) begin bad++; $display("FAIL rstmid_restart_latency: got %0d want 161", done_cyc); end
        total++; if (got_meas !== 8'h6F) begin bad++; $display("FAIL rstmid_restart_measured: got %h want 6f", got_meas); end
    endtask

    task automatic test_back_to_back();
        gate_code = 8'h6F; noise_en = 1'b1; clear_flips();
        extra_start = {5, 100, 161};
        drive_scan();
        extra_start = {};
        total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
        total++; if (done_cyc != 161) begin bad++; $display("FAIL b2b_latency: got %0d want 161", done_cyc); end
        total++; if (!seq_ok) begin bad++; $display("FAIL b2b_drv_busy_walk: got bad sequence want 000..111 then idle"); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_gate_6f();
        test_tied_zero();
        test_glitch_row3();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
